// File: rtl/cprv_csr_pkg.sv
// Shared types and constants for the CSR access unit.
// Zicsr funct3 encodings, privilege levels and CSR addresses.
package cprv_csr_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // addr[11:10] value marking a read-only CSR
  localparam logic [1:0] CSR_RO = 2'b11;

  localparam logic [11:0] CSR_SSTATUS  = 12'h100;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

endpackage

// File: rtl/cprv_csr_perm_check.sv
// Combinational legality check for a Zicsr access:
// opcode, privilege level and read-only write attempts.
module cprv_csr_perm_check
  import cprv_csr_pkg::*;
(
  input  logic [3:0] addr_hi,
  input  logic [1:0] priv,
  input  logic [1:0] op,
  input  logic       do_write,
  output logic       illegal
);

  logic bad_op;
  logic bad_priv;
  logic bad_ro;

  assign bad_op   = (op == 2'b00);
  assign bad_priv = (addr_hi[1:0] > priv);
  assign bad_ro   = do_write && (addr_hi[3:2] == CSR_RO);
  assign illegal  = bad_op || bad_priv || bad_ro;

endmodule

// File: rtl/cprv_csr_access_unit.sv
// Zicsr initiator: read-modify-write of one CSR per request,
// returning the old value or an illegal flag to the pipeline.
module cprv_csr_access_unit
  import cprv_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_csr_addr,
  input  logic [4:0]            req_rs1_idx,
  input  logic [DATA_WIDTH-1:0] req_rs1_data,
  input  logic [1:0]            priv_mode,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_illegal,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_w_en,
  output logic [1:0]            csr_priv_mode,
  input  logic [DATA_WIDTH-1:0] csr_rdata
);

  state_t                state;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic                  src_zero_q;
  logic                  do_write;
  logic                  illegal;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] zimm;

  assign zimm = {{(DATA_WIDTH-5){1'b0}}, req_rs1_idx};

  // RW always writes; RS/RC only when the source is not x0/zimm 0
  assign do_write = (op_q == 2'b01) || !src_zero_q;

  cprv_csr_perm_check u_perm (
    .addr_hi  (csr_addr[ADDR_WIDTH-1:ADDR_WIDTH-4]),
    .priv     (csr_priv_mode),
    .op       (op_q),
    .do_write (do_write),
    .illegal  (illegal)
  );

  always_comb begin
    wdata_next = opnd_q;
    case (op_q)
      2'b10:   wdata_next = csr_rdata | opnd_q;
      2'b11:   wdata_next = csr_rdata & ~opnd_q;
      default: wdata_next = opnd_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_illegal  <= 1'b0;
      resp_rdata    <= '0;
      csr_w_en      <= 1'b0;
      csr_addr      <= '0;
      csr_wdata     <= '0;
      csr_priv_mode <= PRIV_M;
      op_q          <= '0;
      opnd_q        <= '0;
      old_q         <= '0;
      src_zero_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q          <= req_funct3[1:0];
            csr_addr      <= req_csr_addr;
            csr_priv_mode <= priv_mode;
            opnd_q        <= req_funct3[2] ? zimm : req_rs1_data;
            src_zero_q    <= (req_rs1_idx == 5'd0);
            req_ready     <= 1'b0;
            state         <= S_READ;
          end
        end
        S_READ: begin
          if (illegal) begin
            old_q        <= '0;
            resp_rdata   <= '0;
            resp_illegal <= 1'b1;
            resp_valid   <= 1'b1;
            state        <= S_RESP;
          end else if (do_write) begin
            old_q     <= csr_rdata;
            csr_wdata <= wdata_next;
            csr_w_en  <= 1'b1;
            state     <= S_WRITE;
          end else begin
            old_q        <= csr_rdata;
            resp_rdata   <= csr_rdata;
            resp_illegal <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= S_RESP;
          end
        end
        S_WRITE: begin
          csr_w_en     <= 1'b0;
          resp_rdata   <= old_q;
          resp_illegal <= 1'b0;
          resp_valid   <= 1'b1;
          state        <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid   <= 1'b0;
            resp_illegal <= 1'b0;
            req_ready    <= 1'b1;
            state        <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_csr_access_unit.sv
// Bench for cprv_csr_access_unit: directed plan cases plus
// random Zicsr traffic against a CSR-file array and ISA model.
module tb_cprv_csr_access_unit;
  import cprv_csr_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [4:0]  req_rs1_idx;
  logic [63:0] req_rs1_data;
  logic [1:0]  priv_mode;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_illegal;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic        csr_w_en;
  logic [1:0]  csr_priv_mode;
  logic [63:0] csr_rdata;

  logic [63:0] mem [0:4095];
  int total = 0;
  int bad = 0;
  int wen_cnt = 0;
  logic [63:0] last_wdata;
  logic [11:0] last_waddr;

  cprv_csr_access_unit #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_funct3    (req_funct3),
    .req_csr_addr  (req_csr_addr),
    .req_rs1_idx   (req_rs1_idx),
    .req_rs1_data  (req_rs1_data),
    .priv_mode     (priv_mode),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_illegal  (resp_illegal),
    .csr_addr      (csr_addr),
    .csr_wdata     (csr_wdata),
    .csr_w_en      (csr_w_en),
    .csr_priv_mode (csr_priv_mode),
    .csr_rdata     (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_rdata = mem[csr_addr];

  // CSR file: writes land on the clock edge while w_en is high
  always @(posedge clk) begin
    if (csr_w_en) begin
      wen_cnt++;
      last_wdata = csr_wdata;
      last_waddr = csr_addr;
      mem[csr_addr] = csr_wdata;
    end
  end

  // Zicsr semantics straight from the ISA rules
  function automatic void model(
    input  logic [2:0]  f3,
    input  logic [11:0] a,
    input  logic [1:0]  p,
    input  logic [4:0]  idx,
    input  logic [63:0] rs1,
    input  logic [63:0] old,
    output logic        ill,
    output logic        wr,
    output logic [63:0] rd,
    output logic [63:0] nv,
    output int          lat
  );
    logic [63:0] x;
    x = f3[2] ? 64'(idx) : rs1;
    wr = (f3[1:0] == 2'b01) || (idx != 0);
    ill = (f3[1:0] == 2'b00) || (a[9:8] > p)
       || (wr && a[11:10] == 2'b11);
    if (ill) wr = 1'b0;
    rd = ill ? 64'd0 : old;
    case (f3[1:0])
      2'b01:   nv = x;
      2'b10:   nv = old | x;
      2'b11:   nv = old & ~x;
      default: nv = old;
    endcase
    if (!wr) nv = old;
    lat = wr ? 3 : 2;
  endfunction

  task automatic run_txn(
    input string       nm,
    input logic [2:0]  f3,
    input logic [11:0] a,
    input logic [1:0]  p,
    input logic [4:0]  idx,
    input logic [63:0] rs1,
    input int          hold
  );
    logic        e_ill, e_wr;
    logic [63:0] e_rd, e_nv;
    int          e_lat, lat, w0;
    bit          got;
    model(f3, a, p, idx, rs1, mem[a], e_ill, e_wr, e_rd, e_nv, e_lat);
    w0 = wen_cnt;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s.ready got=%b exp=1", nm, req_ready);
    end
    req_funct3 = f3;
    req_csr_addr = a;
    priv_mode = p;
    req_rs1_idx = idx;
    req_rs1_data = rs1;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_funct3 = 3'($urandom);
    req_csr_addr = 12'($urandom);
    req_rs1_data = {$urandom, $urandom};
    lat = 1;
    got = 0;
    while (lat < 8 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (resp_valid) got = 1;
    end
    total++;
    if (!got || lat != e_lat) begin
      bad++;
      $display("FAIL %s.latency got=%0d exp=%0d", nm, lat, e_lat);
    end
    total++;
    if (resp_rdata !== e_rd || resp_illegal !== e_ill) begin
      bad++;
      $display("FAIL %s.resp got=%h/%b exp=%h/%b",
               nm, resp_rdata, resp_illegal, e_rd, e_ill);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0
          || resp_rdata !== e_rd || resp_illegal !== e_ill) begin
        bad++;
        $display("FAIL %s.hold%0d got v=%b r=%b d=%h i=%b exp v=1 r=0 d=%h i=%b",
                 nm, i, resp_valid, req_ready, resp_rdata,
                 resp_illegal, e_rd, e_ill);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s.done got v=%b r=%b exp v=0 r=1",
               nm, resp_valid, req_ready);
    end
    total++;
    if (wen_cnt - w0 != (e_wr ? 1 : 0)) begin
      bad++;
      $display("FAIL %s.wen_pulses got=%0d exp=%0d",
               nm, wen_cnt - w0, e_wr ? 1 : 0);
    end
    if (e_wr) begin
      total++;
      if (last_wdata !== e_nv || last_waddr !== a) begin
        bad++;
        $display("FAIL %s.wdata got=%h@%h exp=%h@%h",
                 nm, last_wdata, last_waddr, e_nv, a);
      end
    end
    total++;
    if (mem[a] !== e_nv) begin
      bad++;
      $display("FAIL %s.csr got=%h exp=%h", nm, mem[a], e_nv);
    end
  endtask

  task automatic test_reset();
    req_valid = 1'b1;
    req_funct3 = CSRRW;
    req_csr_addr = CSR_MTVEC;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0
        || resp_illegal !== 1'b0 || resp_rdata !== 64'd0) begin
      bad++;
      $display("FAIL reset.resp got r=%b v=%b i=%b d=%h exp 1 0 0 0",
               req_ready, resp_valid, resp_illegal, resp_rdata);
    end
    total++;
    if (csr_w_en !== 1'b0 || csr_addr !== 12'd0
        || csr_wdata !== 64'd0 || csr_priv_mode !== 2'd3) begin
      bad++;
      $display("FAIL reset.csr got w=%b a=%h d=%h p=%0d exp 0 0 0 3",
               csr_w_en, csr_addr, csr_wdata, csr_priv_mode);
    end
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset.release got r=%b v=%b exp r=1 v=0",
               req_ready, resp_valid);
    end
  endtask

  task automatic test_directed();
    mem[CSR_MTVEC] = 64'h100;
    run_txn("rw_mtvec", CSRRW, CSR_MTVEC, PRIV_M, 5'd5,
            64'h8000_0000, 0);
    total++;
    if (mem[CSR_MTVEC] !== 64'h8000_0000) begin
      bad++;
      $display("FAIL rw_mtvec.value got=%h exp=80000000",
               mem[CSR_MTVEC]);
    end
    mem[CSR_MSTATUS] = 64'hA00;
    run_txn("rs_x0", CSRRS, CSR_MSTATUS, PRIV_M, 5'd0,
            64'hFFFF, 0);
    mem[CSR_MSTATUS] = 64'hA;
    run_txn("rci", CSRRCI, CSR_MSTATUS, PRIV_M, 5'd8,
            64'hFFFF, 0);
    total++;
    if (mem[CSR_MSTATUS] !== 64'h2) begin
      bad++;
      $display("FAIL rci.value got=%h exp=2", mem[CSR_MSTATUS]);
    end
    mem[CSR_MEPC] = 64'h1234;
    run_txn("u_mepc", CSRRW, CSR_MEPC, PRIV_U, 5'd1,
            64'h55, 0);
    mem[CSR_MHARTID] = 64'h7;
    run_txn("rw_hartid", CSRRW, CSR_MHARTID, PRIV_M, 5'd2,
            64'h1, 0);
    run_txn("rs_hartid", CSRRS, CSR_MHARTID, PRIV_M, 5'd0,
            64'h1, 0);
    run_txn("s_sstatus", CSRRSI, CSR_SSTATUS, PRIV_S, 5'd3,
            64'h0, 0);
    run_txn("op000", 3'b000, CSR_MSCRATCH, PRIV_M, 5'd1,
            64'h9, 0);
  endtask

  task automatic test_stall();
    mem[CSR_MSCRATCH] = 64'hDEAD_BEEF;
    run_txn("stall_w", CSRRC, CSR_MSCRATCH, PRIV_M, 5'd4,
            64'hFF, 5);
    run_txn("stall_ill", CSRRW, CSR_CYCLE, PRIV_M, 5'd4,
            64'hFF, 5);
  endtask

  task automatic test_reset_mid_write();
    int w0;
    mem[CSR_MSCRATCH] = 64'h55;
    w0 = wen_cnt;
    req_funct3 = CSRRW;
    req_csr_addr = CSR_MSCRATCH;
    priv_mode = PRIV_M;
    req_rs1_idx = 5'd3;
    req_rs1_data = 64'h1234;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (csr_w_en !== 1'b1) begin
      bad++;
      $display("FAIL midrst.inwrite got=%b exp=1", csr_w_en);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (csr_w_en !== 1'b0 || req_ready !== 1'b1
        || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst.async got w=%b r=%b v=%b exp 0 1 0",
               csr_w_en, req_ready, resp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (resp_valid !== 1'b0 || wen_cnt != w0
        || mem[CSR_MSCRATCH] !== 64'h55) begin
      bad++;
      $display("FAIL midrst.discard got v=%b n=%0d m=%h exp 0 %0d 55",
               resp_valid, wen_cnt - w0, mem[CSR_MSCRATCH], 0);
    end
    run_txn("after_rst", CSRRS, CSR_MSCRATCH, PRIV_M, 5'd9,
            64'hF00, 1);
  endtask

  task automatic test_random();
    logic [11:0] alist [8];
    logic [11:0] a;
    logic [1:0]  p;
    logic [4:0]  idx;
    alist = '{CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MHARTID,
              CSR_SSTATUS, CSR_CYCLE, CSR_MCAUSE, 12'h000};
    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                      : alist[$urandom_range(0, 7)];
      case ($urandom_range(0, 2))
        0:       p = PRIV_U;
        1:       p = PRIV_S;
        default: p = PRIV_M;
      endcase
      idx = ($urandom_range(0, 2) == 0) ? 5'd0
                                        : 5'($urandom_range(1, 31));
      mem[a] = {$urandom, $urandom};
      run_txn($sformatf("rnd%0d", n), 3'($urandom_range(0, 7)),
              a, p, idx, {$urandom, $urandom},
              $urandom_range(0, 2));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    req_funct3 = '0;
    req_csr_addr = '0;
    req_rs1_idx = '0;
    req_rs1_data = '0;
    priv_mode = PRIV_M;
    for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
